// File: rtl/irq_pkg.sv
// Shared types and constants for the three-level interrupt controller.
// Level encoding, default handler vectors and PC width.
package irq_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL1     = 2'd1,
    LVL2     = 2'd2,
    LVL3     = 2'd3
  } lvl_e;

  localparam logic [PC_W-1:0] VEC1_DEF = 32'h0000_3000;
  localparam logic [PC_W-1:0] VEC2_DEF = 32'h0000_3400;
  localparam logic [PC_W-1:0] VEC3_DEF = 32'h0000_3800;

  function automatic logic [2:0] lvl_mask(lvl_e l);
    logic [2:0] m;
    m = 3'b000;
    unique case (l)
      LVL1:    m = 3'b001;
      LVL2:    m = 3'b010;
      LVL3:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Core-side handshake between the interrupt controller and the CPU.
// master = controller, slave = core exception logic.
interface interrupt_ctrl_if;
  import irq_pkg::*;

  logic            int_en;
  logic            int_ack;
  logic [PC_W-1:0] pc_in;
  logic            eret;
  logic            int_req;
  logic [PC_W-1:0] int_vec;
  logic [PC_W-1:0] epc_out;

  modport master (
    input  int_en,
    input  int_ack,
    input  pc_in,
    input  eret,
    output int_req,
    output int_vec,
    output epc_out
  );

  modport slave (
    output int_en,
    output int_ack,
    output pc_in,
    output eret,
    input  int_req,
    input  int_vec,
    input  epc_out
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Highest-set-bit encoder: bit0 maps to LVL1, bit2 to LVL3.
// Empty mask yields LVL_NONE.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [2:0] mask,
  output lvl_e       lvl
);

  always_comb begin
    lvl = LVL_NONE;
    unique case (1'b1)
      mask[2]:                       lvl = LVL3;
      mask[1] && !mask[2]:           lvl = LVL2;
      mask[0] && (mask[2:1] == 2'b0): lvl = LVL1;
      default:                       lvl = LVL_NONE;
    endcase
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Three-level nesting interrupt controller with a return-PC stack.
// Level 3 is highest; a level preempts only strictly lower in-service ones.
module interrupt_ctrl
  import irq_pkg::*;
#(
  parameter logic [PC_W-1:0] VEC1 = VEC1_DEF,
  parameter logic [PC_W-1:0] VEC2 = VEC2_DEF,
  parameter logic [PC_W-1:0] VEC3 = VEC3_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               inter1,
  input  logic               inter2,
  input  logic               inter3,
  interrupt_ctrl_if.master   core,
  output logic               inter_running1,
  output logic               inter_running2,
  output logic               inter_running3
);

  logic [2:0]      pend_q, pend_d;
  logic [2:0]      isr_q, isr_d;
  logic [1:0]      sp_q, sp_d;
  logic [PC_W-1:0] stk_q [3];
  logic [PC_W-1:0] stk_d [3];

  lvl_e       hp, hi;
  logic       req;
  logic       take, pop;
  logic [1:0] sp_pop;
  logic [2:0] isr_pop;

  irq_prio_enc u_pend_enc (
    .mask (pend_q),
    .lvl  (hp)
  );

  irq_prio_enc u_isr_enc (
    .mask (isr_q),
    .lvl  (hi)
  );

  always_comb begin
    req = core.int_en && (pend_q != 3'b0) && (hp > hi);
    core.int_req = req;
    unique case (hp)
      LVL3:    core.int_vec = VEC3;
      LVL2:    core.int_vec = VEC2;
      default: core.int_vec = VEC1;
    endcase
    core.epc_out = '0;
    for (int i = 0; i < 3; i++) begin
      if (sp_q == 2'(i + 1)) core.epc_out = stk_q[i];
    end
  end

  // Pop before push so ack+eret replaces the top entry in place.
  always_comb begin
    take    = core.int_ack && req;
    pop     = core.eret && (sp_q != 2'd0);
    sp_pop  = pop ? sp_q - 2'd1 : sp_q;
    isr_pop = pop ? (isr_q & ~lvl_mask(hi)) : isr_q;

    pend_d = pend_q;
    isr_d  = isr_pop;
    sp_d   = sp_pop;
    for (int i = 0; i < 3; i++) stk_d[i] = stk_q[i];

    if (take) begin
      pend_d = pend_q & ~lvl_mask(hp);
      isr_d  = isr_pop | lvl_mask(hp);
      sp_d   = sp_pop + 2'd1;
      for (int i = 0; i < 3; i++) begin
        if (sp_pop == 2'(i)) stk_d[i] = core.pc_in;
      end
    end

    // New requests win over a same-cycle acknowledge.
    pend_d = pend_d | {inter3, inter2, inter1};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pend_q <= '0;
      isr_q  <= '0;
      sp_q   <= '0;
      for (int i = 0; i < 3; i++) stk_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      isr_q  <= isr_d;
      sp_q   <= sp_d;
      for (int i = 0; i < 3; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign inter_running1 = isr_q[0];
  assign inter_running2 = isr_q[1];
  assign inter_running3 = isr_q[2];

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: priority, nesting, enable,
// reset and simultaneous ack/eret behaviour.
module tb_interrupt_ctrl;
  import irq_pkg::*;

  localparam logic [31:0] V1 = 32'h0000_3000;
  localparam logic [31:0] V2 = 32'h0000_3400;
  localparam logic [31:0] V3 = 32'h0000_3800;

  logic clk = 1'b0;
  logic clr, inter1, inter2, inter3;
  logic run1, run2, run3;
  int   n_pass = 0;
  int   n_tot  = 0;

  interrupt_ctrl_if bus();

  interrupt_ctrl dut (
    .clk            (clk),
    .clr            (clr),
    .inter1         (inter1),
    .inter2         (inter2),
    .inter3         (inter3),
    .core           (bus),
    .inter_running1 (run1),
    .inter_running2 (run2),
    .inter_running3 (run3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] lines);
    {inter3, inter2, inter1} = lines;
    tick();
    {inter3, inter2, inter1} = 3'b000;
  endtask

  task automatic ack(input logic [31:0] pc);
    bus.int_ack = 1'b1;
    bus.pc_in   = pc;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    n_tot++;
    if (bus.int_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.int_req);
    else n_pass++;
    n_tot++;
    if (bus.int_vec !== V1) $display("FAIL rst_vec got %h exp %h", bus.int_vec, V1);
    else n_pass++;
    n_tot++;
    if (bus.epc_out !== 32'h0) $display("FAIL rst_epc got %h exp 0", bus.epc_out);
    else n_pass++;
    n_tot++;
    if ({run3, run2, run1} !== 3'b000) $display("FAIL rst_run got %b exp 000", {run3, run2, run1});
    else n_pass++;
  endtask

  task automatic test_single();
    pulse(3'b001);
    n_tot++;
    if ({bus.int_req, bus.int_vec} !== {1'b1, V1})
      $display("FAIL single_req got %b/%h exp 1/%h", bus.int_req, bus.int_vec, V1);
    else n_pass++;
    ack(32'h100);
    n_tot++;
    if ({bus.int_req, run1, bus.epc_out} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL single_ack got req=%b run1=%b epc=%h exp 0/1/100", bus.int_req, run1, bus.epc_out);
    else n_pass++;
    do_eret();
    n_tot++;
    if ({bus.int_req, run1, bus.epc_out} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL single_eret got req=%b run1=%b epc=%h exp 0/0/0", bus.int_req, run1, bus.epc_out);
    else n_pass++;
  endtask

  task automatic test_nest();
    pulse(3'b001);
    ack(32'h100);
    pulse(3'b100);
    n_tot++;
    if ({bus.int_req, bus.int_vec} !== {1'b1, V3})
      $display("FAIL nest_req got %b/%h exp 1/%h", bus.int_req, bus.int_vec, V3);
    else n_pass++;
    ack(32'h3010);
    n_tot++;
    if ({run3, run2, run1, bus.epc_out} !== {3'b101, 32'h3010})
      $display("FAIL nest_ack got run=%b epc=%h exp 101/3010", {run3, run2, run1}, bus.epc_out);
    else n_pass++;
    do_eret();
    n_tot++;
    if ({run3, run2, run1, bus.epc_out} !== {3'b001, 32'h100})
      $display("FAIL nest_eret got run=%b epc=%h exp 001/100", {run3, run2, run1}, bus.epc_out);
    else n_pass++;
    do_eret();
  endtask

  task automatic test_low_during_high();
    pulse(3'b100);
    ack(32'h200);
    pulse(3'b001);
    tick();
    n_tot++;
    if ({bus.int_req, run3} !== 2'b01)
      $display("FAIL low_held got req=%b run3=%b exp 0/1", bus.int_req, run3);
    else n_pass++;
    do_eret();
    n_tot++;
    if ({bus.int_req, bus.int_vec} !== {1'b1, V1})
      $display("FAIL low_after got %b/%h exp 1/%h", bus.int_req, bus.int_vec, V1);
    else n_pass++;
    ack(32'h204);
    do_eret();
  endtask

  task automatic test_simul();
    pulse(3'b011);
    n_tot++;
    if ({bus.int_req, bus.int_vec} !== {1'b1, V2})
      $display("FAIL simul_req got %b/%h exp 1/%h", bus.int_req, bus.int_vec, V2);
    else n_pass++;
    ack(32'h400);
    n_tot++;
    if ({bus.int_req, run2, run1} !== 3'b010)
      $display("FAIL simul_ack got req=%b run=%b%b exp 0/10", bus.int_req, run2, run1);
    else n_pass++;
    do_eret();
    n_tot++;
    if ({bus.int_req, bus.int_vec} !== {1'b1, V1})
      $display("FAIL simul_l1 got %b/%h exp 1/%h", bus.int_req, bus.int_vec, V1);
    else n_pass++;
    ack(32'h404);
    do_eret();
  endtask

  task automatic test_enable();
    bus.int_en = 1'b0;
    pulse(3'b101);
    n_tot++;
    if (bus.int_req !== 1'b0) $display("FAIL en_off got %b exp 0", bus.int_req);
    else n_pass++;
    @(negedge clk);
    bus.int_en = 1'b1;
    #1;
    n_tot++;
    if ({bus.int_req, bus.int_vec} !== {1'b1, V3})
      $display("FAIL en_on got %b/%h exp 1/%h", bus.int_req, bus.int_vec, V3);
    else n_pass++;
    clr = 1'b1;
    bus.int_ack = 1'b1;
    bus.pc_in = 32'h777;
    tick();
    clr = 1'b0;
    bus.int_ack = 1'b0;
    n_tot++;
    if ({bus.int_req, run3, run2, run1, bus.epc_out, bus.int_vec} !== {4'b0, 32'h0, V1})
      $display("FAIL clr_ack got req=%b run=%b epc=%h vec=%h exp 0/000/0/%h",
               bus.int_req, {run3, run2, run1}, bus.epc_out, bus.int_vec, V1);
    else n_pass++;
  endtask

  task automatic test_corner();
    do_eret();
    n_tot++;
    if ({bus.int_req, run3, run2, run1, bus.epc_out} !== {4'b0, 32'h0})
      $display("FAIL eret_empty got req=%b run=%b epc=%h exp 0/000/0",
               bus.int_req, {run3, run2, run1}, bus.epc_out);
    else n_pass++;
    pulse(3'b010);
    ack(32'h500);
    pulse(3'b100);
    bus.int_ack = 1'b1;
    bus.eret = 1'b1;
    bus.pc_in = 32'h600;
    tick();
    bus.int_ack = 1'b0;
    bus.eret = 1'b0;
    n_tot++;
    if ({bus.int_req, run3, run2, run1, bus.epc_out} !== {4'b0100, 32'h600})
      $display("FAIL ack_eret got req=%b run=%b epc=%h exp 0/100/600",
               bus.int_req, {run3, run2, run1}, bus.epc_out);
    else n_pass++;
    do_eret();
    n_tot++;
    if ({run3, run2, run1, bus.epc_out} !== {3'b000, 32'h0})
      $display("FAIL ack_eret_pop got run=%b epc=%h exp 000/0", {run3, run2, run1}, bus.epc_out);
    else n_pass++;
  endtask

  task automatic test_merge_set_wins();
    pulse(3'b001);
    pulse(3'b001);
    inter1 = 1'b1;
    ack(32'h800);
    inter1 = 1'b0;
    n_tot++;
    if ({bus.int_req, run1, bus.epc_out} !== {2'b01, 32'h800})
      $display("FAIL set_wins got req=%b run1=%b epc=%h exp 0/1/800", bus.int_req, run1, bus.epc_out);
    else n_pass++;
    do_eret();
    n_tot++;
    if ({bus.int_req, bus.int_vec} !== {1'b1, V1})
      $display("FAIL set_wins_pend got %b/%h exp 1/%h", bus.int_req, bus.int_vec, V1);
    else n_pass++;
    ack(32'h804);
    do_eret();
    n_tot++;
    if ({bus.int_req, run1} !== 2'b00)
      $display("FAIL merged got req=%b run1=%b exp 0/0", bus.int_req, run1);
    else n_pass++;
  endtask

  initial begin
    clr = 1'b1;
    {inter3, inter2, inter1} = 3'b000;
    bus.int_en  = 1'b1;
    bus.int_ack = 1'b0;
    bus.eret    = 1'b0;
    bus.pc_in   = '0;
    test_reset();
    test_single();
    test_nest();
    test_low_during_high();
    test_simul();
    test_enable();
    test_corner();
    test_merge_set_wins();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
